// File: rtl/pipe_stage_elastic_vp.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic_vp
//
// Purpose:
//   Generic elastic stage register that sits between two RV32I pipe stages.
//   It carries an opaque payload plus the rd/regwrite fields the hazard unit
//   inspects. The valid/ready handshake is backed by a main entry (M) and a
//   skid entry (S), so one downstream stall cycle never drops in_ready in the
//   same cycle. A flush squashes everything held.
//
// Parameters:
//   DATA_W  payload width (packed by the instantiator)
//   CTRL_W  control-field width
//   RD_W    destination-register index width
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     upstream handshake
//   in_ctrl, in_data,       incoming instruction fields
//   in_rd, in_regwrite
//   flush                   squash all held instructions
//   out_valid / out_ready   downstream handshake
//   out_ctrl, out_data,     head (M) entry fields
//   out_rd, out_regwrite    (out_regwrite is gated by out_valid)
//   occupancy               number of entries held (0..2)
//
// Optional build macro:
//   PIPE_STAGE_PERF_EN adds stall_cnt[31:0] and bubble_cnt[31:0], saturating
//   performance counters cleared only by reset.
// ---------------------------------------------------------------------------
module pipe_stage_elastic_vp #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 3,
    parameter int RD_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_regwrite,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_regwrite,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    // Main (head) entry
    logic              mv;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [RD_W-1:0]   m_rd;
    logic              m_regwrite;

    // Skid entry, only ever filled while M is stalled
    logic              sv;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic [RD_W-1:0]   s_rd;
    logic              s_regwrite;

    logic accept;
    logic deliver;

    // in_ready depends only on registered state (and reset), never on
    // out_ready, so the ready path does not chain through the stage.
    assign in_ready     = !sv && !reset;
    assign accept       = in_valid && in_ready;
    assign deliver      = mv && out_ready;

    assign out_valid    = mv;
    assign out_ctrl     = m_ctrl;
    assign out_data     = m_data;
    assign out_rd       = m_rd;
    assign out_regwrite = mv && m_regwrite;
    assign occupancy    = {1'b0, mv} + {1'b0, sv};

    // Entry storage. Reset and flush both wipe every field; otherwise S is
    // only written when M is stalled, and S only ever moves into M, which
    // keeps the stage strictly in order. Payload of an entry that drains
    // without replacement is left in place.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            mv         <= 1'b0;
            m_ctrl     <= '0;
            m_data     <= '0;
            m_rd       <= '0;
            m_regwrite <= 1'b0;
            sv         <= 1'b0;
            s_ctrl     <= '0;
            s_data     <= '0;
            s_rd       <= '0;
            s_regwrite <= 1'b0;
        end else if (!mv) begin
            if (accept) begin
                mv         <= 1'b1;
                m_ctrl     <= in_ctrl;
                m_data     <= in_data;
                m_rd       <= in_rd;
                m_regwrite <= in_regwrite;
            end
        end else if (!sv) begin
            if (deliver) begin
                if (accept) begin
                    m_ctrl     <= in_ctrl;
                    m_data     <= in_data;
                    m_rd       <= in_rd;
                    m_regwrite <= in_regwrite;
                end else begin
                    mv <= 1'b0;
                end
            end else if (accept) begin
                sv         <= 1'b1;
                s_ctrl     <= in_ctrl;
                s_data     <= in_data;
                s_rd       <= in_rd;
                s_regwrite <= in_regwrite;
            end
        end else if (deliver) begin
            sv         <= 1'b0;
            m_ctrl     <= s_ctrl;
            m_data     <= s_data;
            m_rd       <= s_rd;
            m_regwrite <= s_regwrite;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating stall/bubble counters. Only reset clears them; a flush is
    // a normal pipeline event and must not disturb the statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (out_ready && !out_valid && (bubble_cnt != 32'hFFFF_FFFF))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stage_elastic_vp.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic_vp
//
// Directed, table-driven bench for pipe_stage_elastic_vp. Each vector holds
// the inputs for one clock cycle plus the hand-computed in_ready before the
// edge and the stage outputs after the edge. A short hand-written sequence
// covers the optional performance counters when PIPE_STAGE_PERF_EN is set.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic_vp;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 3;
    localparam int RD_W   = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              in_regwrite;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_regwrite;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int passCount = 0;
    int totalCount = 0;

    // Free-running 10-time-unit clock
    always #5 clock = ~clock;

    pipe_stage_elastic_vp #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .RD_W  (RD_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_data     (in_data),
        .in_rd       (in_rd),
        .in_regwrite (in_regwrite),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_regwrite(out_regwrite),
        .occupancy   (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        fl;
        logic        ordy;
        logic        expReadyPre;
        logic        expValid;
        logic [31:0] expData;
        logic [4:0]  expRd;
        logic        expRw;
        logic [1:0]  expOcc;
        logic        expReadyPost;
        logic        chkData;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic iv,
                                input logic [31:0] data, input logic [4:0] rd,
                                input logic rw, input logic fl, input logic ordy,
                                input logic eirPre, input logic eov,
                                input logic [31:0] edata, input logic [4:0] erd,
                                input logic erw, input logic [1:0] eocc,
                                input logic eirPost, input logic chk);
        vec_t v;
        v.rst = rst; v.iv = iv; v.data = data; v.rd = rd; v.rw = rw;
        v.fl = fl; v.ordy = ordy;
        v.expReadyPre = eirPre; v.expValid = eov; v.expData = edata;
        v.expRd = erd; v.expRw = erw; v.expOcc = eocc;
        v.expReadyPost = eirPost; v.chkData = chk;
        return v;
    endfunction

    // One comparison: counts it and reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [95:0] actual,
                               input logic [95:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drives one vector at the falling edge, checks in_ready combinationally,
    // then checks the registered outputs just after the rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        @(negedge clock);
        reset       = v.rst;
        in_valid    = v.iv;
        in_data     = {64'd0, v.data};
        in_rd       = v.rd;
        in_ctrl     = v.rd[2:0];
        in_regwrite = v.rw;
        flush       = v.fl;
        out_ready   = v.ordy;
        #1;
        tag = $sformatf("v%0d", idx);
        checkOutput({tag, ".in_ready_pre"}, 96'(in_ready), 96'(v.expReadyPre));
        @(posedge clock);
        #1;
        checkOutput({tag, ".out_valid"}, 96'(out_valid), 96'(v.expValid));
        checkOutput({tag, ".out_regwrite"}, 96'(out_regwrite), 96'(v.expRw));
        checkOutput({tag, ".occupancy"}, 96'(occupancy), 96'(v.expOcc));
        checkOutput({tag, ".in_ready_post"}, 96'(in_ready), 96'(v.expReadyPost));
        if (v.chkData) begin
            checkOutput({tag, ".out_data"}, out_data, {64'd0, v.expData});
            checkOutput({tag, ".out_rd"}, 96'(out_rd), 96'(v.expRd));
            checkOutput({tag, ".out_ctrl"}, 96'(out_ctrl), 96'(v.expRd[2:0]));
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_rd = '0; in_ctrl = '0;
        in_regwrite = 1'b0; flush = 1'b0; out_ready = 1'b0;

        //                rst iv data  rd rw fl rdy | irPre ov edata erd erw occ irPost chk
        // reset
        vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0,   0,   0, 32'h0,  0, 0, 0, 0, 1));
        // first instruction, 1-cycle latency
        vecs.push_back(mk(0, 1, 32'hA5, 7, 1, 0, 1,   1,   1, 32'hA5, 7, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1,   1,   0, 32'h0,  0, 0, 0, 1, 0));
        // full-throughput stream of 8 values
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 32'h10 + 32'(i), 5'(i + 1), 1'(i % 2), 0, 1,
                              1, 1, 32'h10 + 32'(i), 5'(i + 1), 1'(i % 2), 1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1,   1,   0, 32'h0,  0, 0, 0, 1, 0));
        // stall: 1 into M, 2 into S, 3 held upstream, then drain in order
        vecs.push_back(mk(0, 1, 32'h1,  1, 1, 0, 0,   1,   1, 32'h1,  1, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h2,  2, 1, 0, 0,   1,   1, 32'h1,  1, 1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 32'h3,  3, 1, 0, 0,   0,   1, 32'h1,  1, 1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 32'h3,  3, 1, 0, 1,   0,   1, 32'h2,  2, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h3,  3, 1, 0, 1,   1,   1, 32'h3,  3, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1,   1,   0, 32'h0,  0, 0, 0, 1, 0));
        // flush with both entries full; value 9 must be dropped
        vecs.push_back(mk(0, 1, 32'h4,  4, 1, 0, 0,   1,   1, 32'h4,  4, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h5,  5, 1, 0, 0,   1,   1, 32'h4,  4, 1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 32'h9,  9, 1, 1, 0,   0,   0, 32'h0,  0, 0, 0, 1, 1));
        // flush while empty and ready: offered value still dropped
        vecs.push_back(mk(0, 1, 32'h9,  9, 1, 1, 1,   1,   0, 32'h0,  0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1,   1,   0, 32'h0,  0, 0, 0, 1, 1));
        // reset mid-stall discards both entries
        vecs.push_back(mk(0, 1, 32'h6,  6, 1, 0, 0,   1,   1, 32'h6,  6, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h7,  7, 1, 0, 0,   1,   1, 32'h6,  6, 1, 2, 0, 1));
        vecs.push_back(mk(1, 1, 32'h8,  8, 1, 0, 0,   0,   0, 32'h0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0,   1,   0, 32'h0,  0, 0, 0, 1, 1));
        // simultaneous flush and reset behaves as reset
        vecs.push_back(mk(0, 1, 32'hB,  3, 1, 0, 0,   1,   1, 32'hB,  3, 1, 1, 1, 1));
        vecs.push_back(mk(1, 0, 32'h0,  0, 0, 1, 0,   0,   0, 32'h0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0,   1,   0, 32'h0,  0, 0, 0, 1, 1));

        foreach (vecs[i]) applyStimulus(vecs[i], i);

`ifdef PIPE_STAGE_PERF_EN
        // Counter sequence: fresh reset, 3 bubble cycles, fill both entries,
        // 4 stall cycles, then a flush that must not touch the counts.
        applyStimulus(mk(1, 0, 32'h0, 0, 0, 0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 1), 100);
        checkOutput("perf.stall_after_reset", 96'(stall_cnt), 96'd0);
        checkOutput("perf.bubble_after_reset", 96'(bubble_cnt), 96'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(mk(0, 0, 32'h0, 0, 0, 0, 1,  1, 0, 32'h0, 0, 0, 0, 1, 1), 101 + i);
        applyStimulus(mk(0, 1, 32'h21, 1, 1, 0, 0,  1, 1, 32'h21, 1, 1, 1, 1, 1), 104);
        applyStimulus(mk(0, 1, 32'h22, 2, 1, 0, 0,  1, 1, 32'h21, 1, 1, 2, 0, 1), 105);
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(0, 1, 32'h23, 3, 1, 0, 0,  0, 1, 32'h21, 1, 1, 2, 0, 1), 106 + i);
        checkOutput("perf.stall_cnt", 96'(stall_cnt), 96'd4);
        checkOutput("perf.bubble_cnt", 96'(bubble_cnt), 96'd3);
        applyStimulus(mk(0, 0, 32'h0, 0, 0, 1, 0,  0, 0, 32'h0, 0, 0, 0, 1, 1), 110);
        checkOutput("perf.stall_after_flush", 96'(stall_cnt), 96'd4);
        checkOutput("perf.bubble_after_flush", 96'(bubble_cnt), 96'd3);
`endif

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
